// File: rtl/vga_fb_scheduler.sv
// VGA timing generator and single-port frame-buffer arbiter: display scan-out
// owns the pixel slot at phase 0 of every active pixel, the CPU port gets every other slot.
module vga_fb_scheduler #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic [7:0]        RGB,
    output logic              frame_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = $clog2(PIX_DIV + 1);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [PW-1:0]     PH_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]     PH_ONE   = PW'(1'b1);
    localparam logic [PW-1:0]     PH_LAST  = PW'(PIX_DIV - 1);
    localparam logic [HW-1:0]     H_ZERO   = {HW{1'b0}};
    localparam logic [HW-1:0]     H_ONE    = HW'(1'b1);
    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]     V_ZERO   = {VW{1'b0}};
    localparam logic [VW-1:0]     V_ONE    = VW'(1'b1);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_IRQ    = VW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] FB_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] FB_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    logic [PW-1:0]     ph_q, ph_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              irq_q, irq_d;
    logic              rvalid_q, rvalid_d;

    logic ph_wrap_s, h_wrap_s, v_wrap_s, active_s, disp_slot_s, cpu_ack_s;

    // Position decode shared by the arbiter and the counters.
    always_comb begin
        ph_wrap_s   = (ph_q == PH_LAST);
        h_wrap_s    = (h_q == H_LAST);
        v_wrap_s    = (v_q == V_LAST);
        active_s    = (h_q < H_ACT) && (v_q < V_ACT);
        disp_slot_s = (ph_q == PH_ZERO) && active_s;
        cpu_ack_s   = RESET && cpu_req && !disp_slot_s;
    end

    // RAM port mux: the display slot always wins, the CPU takes any other cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = FB_ZERO;
        ram_wdata = 8'h00;
        if (RESET && disp_slot_s) begin
            ram_en   = 1'b1;
            ram_addr = fb_addr_q;
        end else if (cpu_ack_s) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_we ? cpu_wdata : 8'h00;
        end else begin
            ram_en = 1'b0;
        end
    end

    // Phase, pixel and line counters.
    always_comb begin
        ph_d = ph_wrap_s ? PH_ZERO : ph_q + PH_ONE;
        h_d  = h_q;
        v_d  = v_q;
        if (ph_wrap_s) begin
            h_d = h_wrap_s ? H_ZERO : h_q + H_ONE;
            if (h_wrap_s) begin
                v_d = v_wrap_s ? V_ZERO : v_q + V_ONE;
            end else begin
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
        end
    end

    // Scan-out address walks linearly through the visible area and rewinds per frame.
    always_comb begin
        fb_addr_d = fb_addr_q;
        if (disp_slot_s) begin
            fb_addr_d = fb_addr_q + FB_ONE;
        end else if (ph_wrap_s && h_wrap_s && v_wrap_s) begin
            fb_addr_d = FB_ZERO;
        end else begin
            fb_addr_d = fb_addr_q;
        end
    end

    // Pixel outputs update once per pixel, when the display read data has arrived.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (ph_q == PH_ONE) begin
            rgb_d   = active_s ? ram_rdata : 8'h00;
            hsync_d = !in_window(32'(h_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
            vsync_d = !in_window(32'(v_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Frame interrupt and CPU read-valid strobes.
    always_comb begin
        irq_d    = ph_wrap_s && h_wrap_s && (v_q == V_IRQ);
        rvalid_d = cpu_ack_s && !cpu_we;
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ph_q      <= PH_ZERO;
            h_q       <= H_ZERO;
            v_q       <= V_ZERO;
            fb_addr_q <= FB_ZERO;
            rgb_q     <= 8'h00;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fb_addr_q <= fb_addr_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Read data comes straight from the RAM, one cycle after the acked read.
    always_comb begin
        cpu_ack    = cpu_ack_s;
        cpu_rvalid = rvalid_q;
        cpu_rdata  = rvalid_q ? ram_rdata : 8'h00;
        HSYNC      = hsync_q;
        VSYNC      = vsync_q;
        RGB        = rgb_q;
        frame_irq  = irq_q;
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: small raster, behavioural reference model checked
// every cycle plus directed literal checks of timing, arbitration and reset.
module tb_vga_fb_scheduler;

    localparam int PD = 4;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = 8'h00;
    logic          cpu_ack, cpu_rvalid, ram_en, ram_we, HSYNC, VSYNC, frame_irq;
    logic [7:0]    cpu_rdata, ram_wdata, ram_rdata, RGB;
    logic [AW-1:0] ram_addr;

    int tests = 0;
    int fails = 0;
    int sc = 0;

    vga_fb_scheduler #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ADDR_W(AW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB), .frame_irq(frame_irq)
    );

    always #5 CLK = ~CLK;

    // Frame-buffer RAM: synchronous, read data one cycle after the strobe.
    logic [7:0] mem [256];
    logic       ram_init = 1'b0;
    logic [7:0] rdata_r = 8'h00;
    assign ram_rdata = rdata_r;
    always @(posedge CLK) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
            ram_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else rdata_r <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: position from elapsed cycles, outputs from the raster rules.
    logic [7:0] exp_mem [256];
    initial begin : model
        int cyc, ph, p, h, v;
        bit act, disp, ack_e, rv_e, hs_e, vs_e;
        logic [7:0] pend, shown, rd_e;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i + 1);
        cyc = 0; rv_e = 0; rd_e = 8'h00; pend = 8'h00; shown = 8'h00; hs_e = 1; vs_e = 1;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                chk("rst_hsync", 32'(HSYNC), 1);
                chk("rst_vsync", 32'(VSYNC), 1);
                chk("rst_rgb", 32'(RGB), 0);
                chk("rst_ram_en", 32'(ram_en), 0);
                chk("rst_ack", 32'(cpu_ack), 0);
                chk("rst_rvalid", 32'(cpu_rvalid), 0);
                chk("rst_irq", 32'(frame_irq), 0);
                cyc = 0; rv_e = 0; shown = 8'h00; hs_e = 1; vs_e = 1;
            end else begin
                ph = cyc % PD;
                p = cyc / PD;
                h = p % HT;
                v = (p / HT) % VT;
                act = (h < HA) && (v < VA);
                disp = (ph == 0) && act;
                ack_e = cpu_req && !disp;
                chk("ram_en", 32'(ram_en), 32'(disp || cpu_req));
                chk("cpu_ack", 32'(cpu_ack), 32'(ack_e));
                if (disp) begin
                    chk("disp_addr", 32'(ram_addr), v * HA + h);
                    chk("disp_we", 32'(ram_we), 0);
                end else if (cpu_req) begin
                    chk("cpu_addr", 32'(ram_addr), 32'(cpu_addr));
                    chk("cpu_we", 32'(ram_we), 32'(cpu_we));
                    if (cpu_we) chk("cpu_wdata", 32'(ram_wdata), 32'(cpu_wdata));
                end
                if (ph == 0) pend = act ? exp_mem[v * HA + h] : 8'h00;
                if (ph == 2) begin
                    shown = pend;
                    hs_e = !(h >= HA + HF && h < HA + HF + HS);
                    vs_e = !(v >= VA + VF && v < VA + VF + VS);
                end
                chk("rgb", 32'(RGB), 32'(shown));
                chk("hsync", 32'(HSYNC), 32'(hs_e));
                chk("vsync", 32'(VSYNC), 32'(vs_e));
                chk("irq", 32'(frame_irq), 32'(ph == 0 && h == 0 && v == VA));
                chk("rvalid", 32'(cpu_rvalid), 32'(rv_e));
                if (rv_e) chk("rdata", 32'(cpu_rdata), 32'(rd_e));
                rv_e = ack_e && !cpu_we;
                rd_e = exp_mem[cpu_addr];
                if (ack_e && cpu_we) exp_mem[cpu_addr] = cpu_wdata;
                cyc++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
        sc++;
    endtask

    task automatic go_to(input int k);
        while (sc < k) step();
    endtask

    initial begin : stim
        int hs_lo, vs_lo, irqs, nz, a16, a20, a_ph0;
        logic [7:0] act_rgb [$];
        logic [AW-1:0] dq [$];
        #1 RESET = 1'b0;
        repeat (3) step();
        RESET = 1'b1;
        sc = 0;
        #4;
        hs_lo = 0; vs_lo = 0; irqs = 0; nz = 0;
        for (int i = 0; i < 196; i++) begin
            if (i < 192) begin
                hs_lo += int'(!HSYNC);
                vs_lo += int'(!VSYNC);
                irqs += int'(frame_irq);
                if (i % 4 == 2) begin
                    nz += int'(RGB != 8'h00);
                    if ((i / 4) % HT < HA && (i / 4) / HT < VA) act_rgb.push_back(RGB);
                end
            end
            if (i % 4 == 0 && ram_en) dq.push_back(ram_addr);
            step();
            #4;
        end
        chk("hsync_low_cycles", 32'(hs_lo), 48);
        chk("vsync_low_cycles", 32'(vs_lo), 32);
        chk("irq_per_frame", 32'(irqs), 1);
        chk("nonzero_pixels", 32'(nz), 12);
        chk("active_pixels", 32'(act_rgb.size()), 12);
        for (int k = 0; k < act_rgb.size(); k++) chk("rgb_seq", 32'(act_rgb[k]), 32'(k + 1));
        chk("disp_reads", 32'(dq.size()), 13);
        for (int k = 0; k < 12 && k < dq.size(); k++) chk("disp_addr_seq", 32'(dq[k]), 32'(k));
        if (dq.size() > 12) chk("disp_addr_wrap", 32'(dq[12]), 0);

        // CPU write at phase 0 of an active pixel (0,1): stalled one cycle.
        go_to(224);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 8'hAA;
        #4 chk("wr_stall", 32'(cpu_ack), 0);
        step();
        #4 chk("wr_ack", 32'(cpu_ack), 1);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU read during horizontal blanking: acked at once.
        go_to(240);
        cpu_req = 1'b1; cpu_addr = 8'd5;
        #4 chk("rd_ack_same_cycle", 32'(cpu_ack), 1);
        step();
        cpu_req = 1'b0;
        #4;
        chk("rd_rvalid", 32'(cpu_rvalid), 1);
        chk("rd_rdata", 32'(cpu_rdata), 6);

        go_to(398);
        #4 chk("rgb_written_pixel", 32'(RGB), 32'hAA);

        // Held request across four active pixels and into blanking.
        go_to(416);
        a16 = 0; a20 = 0; a_ph0 = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'(i);
            #4;
            a20 += int'(cpu_ack);
            if (i < 16) a16 += int'(cpu_ack);
            if (i < 16 && i % 4 == 0) a_ph0 += int'(cpu_ack);
            step();
        end
        cpu_req = 1'b0;
        chk("burst_acks_active", 32'(a16), 12);
        chk("burst_acks_ph0", 32'(a_ph0), 0);
        chk("burst_acks_total", 32'(a20), 16);

        // Reset in the middle of pixel (2,1).
        go_to(617);
        RESET = 1'b0;
        #4;
        chk("mid_rst_hsync", 32'(HSYNC), 1);
        chk("mid_rst_vsync", 32'(VSYNC), 1);
        chk("mid_rst_rgb", 32'(RGB), 0);
        repeat (3) step();
        RESET = 1'b1;
        sc = 0;
        #4;
        chk("first_read_en", 32'(ram_en), 1);
        chk("first_read_addr", 32'(ram_addr), 0);
        hs_lo = 0; irqs = 0;
        for (int i = 0; i < 192; i++) begin
            hs_lo += int'(!HSYNC);
            irqs += int'(frame_irq);
            step();
            #4;
        end
        chk("post_rst_hsync_low", 32'(hs_lo), 48);
        chk("post_rst_irq", 32'(irqs), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
